exec_unit_md: RTL
=================

// Module: exec_unit_md
// PURPOSE
//  Next-generation execute stage: parametrised integer ALU plus iterative RV32M multiply/divide.
//  Sits between decode/register-read and writeback.
//  - Valid/ready handshake in and out; one-entry output register.
//  - Single-cycle ops complete in 1 cycle; MUL*/DIV*/REM* take XLEN+2 cycles.
//  - Carries a tag so writeback can match each result to its instruction.
// PARAMETERS
//  XLEN   32  datapath width (>=8, power of 2); shift amount = b[$clog2(XLEN)-1:0]
//  TAG_W  5   width of the tag passed through (destination register index)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous reset, active low
//  flush       in   1        abort any in-flight op and drop the held result
//  in_valid    in   1        operation offered
//  in_ready    out  1        operation accepted when in_valid & in_ready
//  in_op       in   5        exec_pkg::op_e
//  in_a        in   XLEN     operand A (rs1)
//  in_b        in   XLEN     operand B (rs2 or immediate)
//  in_tag      in   TAG_W    passed through unchanged
//  out_valid   out  1        result held
//  out_ready   in   1        consumer takes the result when out_valid & out_ready
//  out_result  out  XLEN     result
//  out_zero    out  1        out_result == 0
//  out_neg     out  1        out_result[XLEN-1]
//  out_tag     out  TAG_W    tag of the result
//  busy        out  1        multi-cycle op in progress
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; every output register = 0.
//    in_ready=0 while rst_n=0.
//  - Ops 0x00 ADD, 0x01 SUB, 0x02 SLL, 0x03 XOR, 0x04 SRL, 0x05 SRA, 0x06 OR, 0x07 AND,
//    0x08 SLT (signed), 0x09 PASSB, 0x0A SLTU.
//  - Ops 0x10..0x17 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU per RISC-V M.
//    Other codes: result 0, latency 1.
//  - All arithmetic is modulo 2^XLEN. SLT/SLTU return 1 or 0. Flags come from the registered result.
//  - in_ready = rst_n & ~flush & (state==IDLE) & (~out_valid | out_ready).
//    A result may drain and a new op be accepted in the same cycle.
//  - Op accepted at edge T:
//    - Single-cycle ops: out_valid=1 after edge T+1.
//    - MUL/DIV: state goes IDLE->RUN at T. RUN iterates XLEN cycles, then FIX applies sign
//      correction, then DONE loads the output: out_valid=1 after edge T+XLEN+2.
//  - busy=1 in RUN and FIX.
//  - Special cases skip RUN and complete at T+1:
//    - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
//    - signed overflow (MIN / -1): DIV = MIN; REM = 0.
//  - out_valid, out_result and out_tag stay stable until out_ready is seen; out_valid then clears
//    unless a new result loads on the same edge.
//  - flush=1 at edge E: state->IDLE, out_valid->0 after E, and no op is accepted at E.
//    flush takes priority over both completion and acceptance.
//  - rst_n low mid-operation acts as flush and also zeroes the datapath registers.
//  - Operands are latched on acceptance, so in_a/in_b/in_op may change while busy.
// STRUCTURE
//  - exec_pkg holds op_e enum, op-group helper functions is_md()/is_div()/is_signed_a()/is_signed_b(),
//    and default XLEN.
//  - Sub-module muldiv_seq (XLEN): radix-2 shift-add multiplier / restoring divider.
//    - Takes start, |a|, |b| and op; returns a 2*XLEN product or quotient/remainder, and done.
//    - Sign fixup and special cases stay in exec_unit_md, along with the FSM IDLE/RUN/FIX/DONE.
//  - Single-cycle ALU is a combinational case in the parent feeding the output register.
// TESTING
//  1. ADD a=0x7FFFFFFF b=1, tag 3 -> 1 cycle later out_result=0x80000000, neg=1, zero=0, tag=3.
//  2. SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; SRA a=0x80000000 b=4 -> 0xF8000000.
//  3. MULH a=0x80000000 b=0x80000000 -> 0x40000000 after exactly 34 cycles; busy=1 cycles 1..33.
//     MULHSU a=-1 b=2 -> 0xFFFFFFFF.
//  4. DIV a=-7 b=2 -> 0xFFFFFFFD; REM a=-7 b=2 -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF at T+1;
//     DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  5. Back-pressure: hold out_ready=0 with a result pending -> in_ready=0 and result stable;
//     release with in_valid=1 -> drain and accept on the same edge.
//  6. flush at cycle 10 of a DIV -> no out_valid, busy=0 next cycle; following ADD 2+3 -> 5.
//     rst_n=0 mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcode enum, FSM states and op-group helpers.
package exec_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_SLL    = 5'h02,
        OP_XOR    = 5'h03,
        OP_SRL    = 5'h04,
        OP_SRA    = 5'h05,
        OP_OR     = 5'h06,
        OP_AND    = 5'h07,
        OP_SLT    = 5'h08,
        OP_PASSB  = 5'h09,
        OP_SLTU   = 5'h0A,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_md(input op_e op);
        return (5'(op) >= 5'h10) && (5'(op) <= 5'h17);
    endfunction

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/exec_unit_md_muldiv_seq.sv
// Radix-2 unsigned shift-add multiplier / restoring divider, one bit per cycle.
module muldiv_seq
    import exec_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              start,
    input  op_e               op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder,
    output logic              done
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            running;
    logic            div_mode;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] m_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    // hi:lo is the running product (multiplier shifts out of lo) or remainder:quotient
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, m_q};

    assign done      = running && (cnt == LAST);
    assign product   = {hi_q, lo_q};
    assign quotient  = lo_q;
    assign remainder = hi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= is_div(op);
            cnt      <= '0;
            m_q      <= is_div(op) ? b : a;
            lo_q     <= is_div(op) ? a : b;
            hi_q     <= '0;
        end else if (running) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                running <= 1'b0;
            end
            if (div_mode) begin
                if (!div_diff[XLEN]) begin
                    hi_q <= div_diff[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_q <= div_shift[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_q <= mul_sum[XLEN:1];
                lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/exec_unit_md.sv
// Execute stage: single-cycle integer ALU plus iterative RV32M mul/div behind a valid/ready handshake.
module exec_unit_md
    import exec_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e             state;
    op_e                op_q;
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    b_q;
    logic [TAG_W-1:0]   tag_q;
    logic               a_neg_q;
    logic               b_neg_q;
    logic [XLEN-1:0]    md_res_q;

    logic               accept;
    logic               div_zero;
    logic               div_ovf;
    logic               md_start;
    logic [XLEN-1:0]    abs_a;
    logic [XLEN-1:0]    abs_b;
    logic [XLEN-1:0]    special_res;
    logic [2*XLEN-1:0]  md_prod;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    md_quot;
    logic [XLEN-1:0]    md_rem;
    logic               md_done;
    logic [XLEN-1:0]    fix_res;
    logic [XLEN-1:0]    done_res;

    function automatic logic [XLEN-1:0] alu(input op_e op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SLL:   return a << sh;
            OP_XOR:   return a ^ b;
            OP_SRL:   return a >> sh;
            OP_SRA:   return $unsigned($signed(a) >>> sh);
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            OP_SLT:   return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_PASSB: return b;
            OP_SLTU:  return {{(XLEN-1){1'b0}}, a < b};
            default:  return '0;
        endcase
    endfunction

    assign in_ready = rst_n && !flush && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_RUN) || (state == S_FIX);

    assign div_zero = is_div(in_op) && (in_b == '0);
    assign div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_VAL) && (in_b == '1);
    assign md_start = accept && is_md(in_op) && !div_zero && !div_ovf;
    assign abs_a    = (is_signed_a(in_op) && in_a[XLEN-1]) ? -in_a : in_a;
    assign abs_b    = (is_signed_b(in_op) && in_b[XLEN-1]) ? -in_b : in_b;

    // Divide-by-zero and MIN/-1 are resolved at acceptance and never enter the iterator
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_a;
        end else if (div_ovf) begin
            special_res = (in_op == OP_DIV) ? MIN_VAL : '0;
        end
    end

    muldiv_seq #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush),
        .start     (md_start),
        .op        (in_op),
        .a         (abs_a),
        .b         (abs_b),
        .product   (md_prod),
        .quotient  (md_quot),
        .remainder (md_rem),
        .done      (md_done)
    );

    // Restore signs on the magnitude result; remainder takes the dividend's sign
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -md_prod : md_prod;
        fix_res  = '0;
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = (a_neg_q ^ b_neg_q) ? -md_quot : md_quot;
            OP_REM, OP_REMU:              fix_res = a_neg_q ? -md_rem : md_rem;
            default:                      fix_res = '0;
        endcase
    end

    assign done_res = is_md(op_q) ? md_res_q : alu(op_q, a_q, b_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            md_res_q   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= in_op;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        tag_q    <= in_tag;
                        a_neg_q  <= is_signed_a(in_op) && in_a[XLEN-1];
                        b_neg_q  <= is_signed_b(in_op) && in_b[XLEN-1];
                        md_res_q <= special_res;
                        state    <= md_start ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (md_done) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    md_res_q <= fix_res;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid || out_ready) begin
                        out_valid  <= 1'b1;
                        out_result <= done_res;
                        out_zero   <= (done_res == '0);
                        out_neg    <= done_res[XLEN-1];
                        out_tag    <= tag_q;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
